led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED sequencer: two debounced active-low buttons drive a 10-bit counter that is
// stepped manually or auto-counted up/down on a prescaled tick.
module led_seq_ctrl #(
  parameter int unsigned DB_CYCLES = 1500,
  parameter int unsigned TICK_DIV  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_step,
  output logic [9:0] leds,
  output logic [1:0] mode
);

  localparam int unsigned DbW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned PsW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);
  localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);

  // Button index 0 is mode, index 1 is step.
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnStep = 1;

  typedef enum logic [1:0] {
    StManual = 2'b00,
    StUp     = 2'b01,
    StDown   = 2'b10,
    StBad    = 2'b11
  } state_e;

  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     stable_q, stable_d;
  logic [1:0]     press_q, press_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  state_e         state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [9:0]     leds_q, leds_d;
  logic           tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      stable_q    <= 2'b11;
      press_q     <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= StManual;
      presc_q     <= '0;
      leds_q      <= '0;
    end else begin
      sync1_q     <= {btn_step, btn_mode};
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      presc_q     <= presc_d;
      leds_q      <= leds_d;
    end
  end

  // A level is accepted only after it has disagreed with stable for DB_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      if (stable_q[i] != sync2_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign tick = ((state_q == StUp) || (state_q == StDown)) && (presc_q == PsMax);

  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    presc_d = '0;

    case (state_q)
      StUp, StDown: presc_d = tick ? '0 : presc_q + PsW'(1);
      default:      presc_d = '0;
    endcase

    // Priority mode > step > tick; losers are dropped, not queued.
    if (state_q == StBad) begin
      state_d = StManual;
      presc_d = '0;
    end else if (press_q[BtnMode]) begin
      presc_d = '0;
      case (state_q)
        StManual: state_d = StUp;
        StUp:     state_d = StDown;
        default:  state_d = StManual;
      endcase
    end else if (press_q[BtnStep]) begin
      presc_d = '0;
      if (state_q == StManual) begin
        leds_d = leds_q + 10'd1;
      end else begin
        leds_d = '0;
      end
    end else if (tick) begin
      if (state_q == StUp) begin
        leds_d = leds_q + 10'd1;
      end else begin
        leds_d = leds_q - 10'd1;
      end
    end
  end

  assign leds = leds_q;
  assign mode = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected {mode, leds} values are queued as
// stimulus is applied and popped whenever the DUT outputs change.
module tb_led_seq_ctrl;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned TickDiv  = 8;
  // Raw edge -> press pulse is DbCycles+2; the counter registers it one cycle later.
  localparam int unsigned PressLat = DbCycles + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b1;
  logic       btn_step = 1'b1;
  logic [9:0] leds;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int chg_cnt = 0;
  int chg_cyc = 0;
  bit mon_en = 1'b0;

  logic [11:0] sb_q[$];
  logic [11:0] prev_obs = 12'h000;
  logic [11:0] mon_obs;
  logic [11:0] mon_exp;

  led_seq_ctrl #(
    .DB_CYCLES(DbCycles),
    .TICK_DIV (TickDiv)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_step(btn_step),
    .leds    (leds),
    .mode    (mode)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every change of {mode, leds} must match the next queued value.
  always @(negedge clock) begin
    if (mon_en) begin
      mon_obs = {mode, leds};
      if (mon_obs !== prev_obs) begin
        if (sb_q.size() == 0) begin
          chk("spurious change", 32'(mon_obs), 32'(prev_obs));
        end else begin
          mon_exp = sb_q.pop_front();
          chk("scoreboard {mode,leds}", 32'(mon_obs), 32'(mon_exp));
        end
        prev_obs = mon_obs;
        chg_cnt++;
        chg_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_from(input int start);
    int k;
    k = 0;
    while (chg_cnt == start && k < 40) begin
      tick();
      k++;
    end
    if (chg_cnt == start) chk("timeout waiting for output change", chg_cnt, start + 1);
  endtask

  task automatic expect_out(input logic [1:0] m, input logic [9:0] l);
    int s;
    s = chg_cnt;
    sb_q.push_back({m, l});
    wait_from(s);
  endtask

  initial begin
    int t0;
    int s;

    // Reset values
    idle(3);
    chk("reset leds", 32'(leds), 0);
    chk("reset mode", 32'(mode), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Clean step press in MANUAL
    btn_step = 1'b0;
    t0 = cyc;
    expect_out(2'b00, 10'd1);
    chk("step press latency", chg_cyc - t0, PressLat);
    idle(13);
    btn_step = 1'b1;
    idle(10);

    // Bounce then hold: one increment
    for (int i = 0; i < 6; i++) begin
      btn_step = (i % 2) != 0;
      idle(2);
    end
    btn_step = 1'b0;
    expect_out(2'b00, 10'd2);
    idle(12);
    btn_step = 1'b1;
    idle(10);

    // Short glitches alone: no change
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b0;
      idle(3);
      btn_step = 1'b1;
      idle(6);
    end
    idle(10);

    // UP auto count
    btn_mode = 1'b0;
    expect_out(2'b01, 10'd2);
    btn_mode = 1'b1;
    expect_out(2'b01, 10'd3);
    t0 = chg_cyc;
    expect_out(2'b01, 10'd4);
    chk("UP tick interval", chg_cyc - t0, TickDiv);

    // DOWN counts through 0 -> 1023 -> 1022
    btn_mode = 1'b0;
    expect_out(2'b10, 10'd4);
    btn_mode = 1'b1;
    for (int v = 3; v >= 0; v--) expect_out(2'b10, 10'(v));
    expect_out(2'b10, 10'd1023);
    expect_out(2'b10, 10'd1022);

    // MANUAL then UP from 1022: 1023 then 0
    btn_mode = 1'b0;
    expect_out(2'b00, 10'd1022);
    btn_mode = 1'b1;
    idle(10);
    btn_mode = 1'b0;
    expect_out(2'b01, 10'd1022);
    btn_mode = 1'b1;
    expect_out(2'b01, 10'd1023);
    t0 = chg_cyc;
    expect_out(2'b01, 10'd0);
    chk("UP wrap tick interval", chg_cyc - t0, TickDiv);

    // DOWN from 0: 1023, first tick a full period after the state change
    btn_mode = 1'b0;
    expect_out(2'b10, 10'd0);
    t0 = chg_cyc;
    btn_mode = 1'b1;
    expect_out(2'b10, 10'd1023);
    chk("prescaler cleared on mode change", chg_cyc - t0, TickDiv);

    // Back to MANUAL; step wraps 1023 -> 0
    btn_mode = 1'b0;
    expect_out(2'b00, 10'd1023);
    btn_mode = 1'b1;
    idle(10);
    btn_step = 1'b0;
    expect_out(2'b00, 10'd0);
    btn_step = 1'b1;
    idle(10);

    // Simultaneous mode+step in UP at leds=5: mode wins, step dropped
    btn_mode = 1'b0;
    expect_out(2'b01, 10'd0);
    btn_mode = 1'b1;
    for (int v = 1; v <= 5; v++) expect_out(2'b01, 10'(v));
    btn_mode = 1'b0;
    btn_step = 1'b0;
    expect_out(2'b10, 10'd5);
    t0 = chg_cyc;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    expect_out(2'b10, 10'd4);
    chk("simultaneous press prescaler clear", chg_cyc - t0, TickDiv);

    // Clear in UP at leds=37
    btn_mode = 1'b0;
    expect_out(2'b00, 10'd4);
    btn_mode = 1'b1;
    idle(10);
    btn_mode = 1'b0;
    expect_out(2'b01, 10'd4);
    btn_mode = 1'b1;
    for (int v = 5; v <= 37; v++) expect_out(2'b01, 10'(v));
    btn_step = 1'b0;
    t0 = cyc;
    expect_out(2'b01, 10'd0);
    chk("UP clear latency", chg_cyc - t0, PressLat);
    t0 = chg_cyc;
    btn_step = 1'b1;
    expect_out(2'b01, 10'd1);
    chk("tick after clear", chg_cyc - t0, TickDiv);

    // Mid-operation reset at leds=100, prescaler=5
    for (int v = 2; v <= 100; v++) expect_out(2'b01, 10'(v));
    idle(5);
    s = chg_cnt;
    sb_q.push_back({2'b00, 10'd0});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_from(s);
    idle(20);
    chk("post-reset leds", 32'(leds), 0);
    chk("post-reset mode", 32'(mode), 0);

    // Button held low through reset: press fires after reset release
    btn_step = 1'b0;
    reset = 1'b1;
    idle(4);
    chk("no press during reset", 32'(leds), 0);
    s = chg_cnt;
    sb_q.push_back({2'b00, 10'd1});
    reset = 1'b0;
    t0 = cyc;
    wait_from(s);
    chk("press after reset latency", chg_cyc - t0, PressLat);
    btn_step = 1'b1;
    idle(15);

    chk("scoreboard drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
